uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
Single-clock first-word-fall-through FIFO that sources the UART transmitter's byte interface. It presents the head byte on RD_DATA and its level on F_EMPTY, and pops when the transmitter's Busy rises. Upstream logic writes bytes with a simple WR_EN strobe. It sits in the TX_CLK domain between the system write path and the UART TX.

Parameters:
DATA_WIDTH, 8, byte width (matches UART TX P_DATA)
DEPTH, 8, number of entries; power of two, >= 2
ADDR_WIDTH, clog2(DEPTH), pointer width (derived, not overridden)

Ports:
CLK  input  1  transmit clock (TX_CLK domain)
RST  input  1  asynchronous, active-low reset
WR_EN  input  1  write strobe, one entry per cycle high
WR_DATA  input  DATA_WIDTH  byte to enqueue
BUSY  input  1  UART TX busy; its 0->1 edge pops the head entry
CLR_ERR  input  1  synchronous clear of the OVF/UNF sticky flags
RD_DATA  output  DATA_WIDTH  head entry (FWFT), valid when F_EMPTY=0
F_EMPTY  output  1  FIFO empty
FULL  output  1  FIFO full
COUNT  output  ADDR_WIDTH+1  current occupancy 0..DEPTH
OVF  output  1  sticky: write attempted while full and no pop
UNF  output  1  sticky: BUSY rise while empty

Behaviour:
- Reset (RST=0, async): wr_ptr=rd_ptr=0, COUNT=0, F_EMPTY=1, FULL=0, OVF=0, UNF=0, busy_d=0, memory cleared to 0, so RD_DATA=0.
- Edge detect: busy_d <= BUSY each cycle. pop_req = BUSY & ~busy_d (combinational). pop = pop_req & ~F_EMPTY.
- Write: wr = WR_EN & (~FULL | pop). On the edge, mem[wr_ptr] <= WR_DATA and wr_ptr increments modulo DEPTH.
- Pop: on the edge, rd_ptr increments modulo DEPTH. RD_DATA = mem[rd_ptr] combinationally.
- Latency:
  - Write at edge N: F_EMPTY falls and RD_DATA is valid in cycle N+1.
  - Pop at edge N: the next entry appears on RD_DATA in cycle N+1.
- COUNT:
  - +1 on wr only, -1 on pop only.
  - Unchanged when wr and pop occur together, or when neither occurs.
  - F_EMPTY = (COUNT==0); FULL = (COUNT==DEPTH). Both are derived from the registered COUNT.
- Pointers use ADDR_WIDTH bits and wrap at DEPTH-1 -> 0. The extra COUNT bit disambiguates full from empty.
- Full + WR_EN + pop in the same cycle: write accepted, COUNT stays DEPTH, no OVF.
- Full + WR_EN without pop: write dropped, memory and pointers unchanged, OVF <= 1.
- Empty + WR_EN + pop_req: pop suppressed, write accepted, COUNT -> 1, UNF <= 1. The new byte is not consumed.
- Empty + pop_req without write: nothing changes, UNF <= 1.
- BUSY held high across many cycles gives exactly one pop. BUSY falling has no effect.
- CLR_ERR=1 clears OVF/UNF on the next edge. If a new error occurs in the same cycle, the set wins.
- Reset mid-operation discards all contents. busy_d=0 after reset, so if BUSY is still high after reset release, the next cycle sees a rise: UNF sets and no pop occurs (FIFO is empty).
- No combinational path from WR_EN to F_EMPTY, FULL or COUNT. RD_DATA depends only on registers.

Decomposition:
- Shared package uart_pkg:
  - DATA_WIDTH default (8)
  - default FIFO depth constant
  - clog2 function used for ADDR_WIDTH
- One natural sub-module: uart_edge_det.
  - Generic rising-edge pulse generator: CLK, RST, async active-low, level in, pulse out.
  - Used for BUSY and reusable on the RX DATA_VLD path.

Test Plan:
- Reset then idle: F_EMPTY=1, FULL=0, COUNT=0, RD_DATA=0x00, OVF=UNF=0.
- Write 0xA5 at edge N: cycle N+1 shows RD_DATA=0xA5, F_EMPTY=0, COUNT=1. BUSY 0->1 held 12 cycles: exactly one pop, F_EMPTY=1, COUNT=0.
- Write 0x01..0x08 (DEPTH=8): FULL=1, COUNT=8. Write 0x09 without pop: dropped, OVF=1, RD_DATA=0x01. Pulse CLR_ERR: OVF=0.
- Full, then WR_EN=0x09 in the same cycle as a BUSY rise: COUNT stays 8. Subsequent pops yield 0x02..0x09 in order, including pointer wrap.
- Empty, BUSY rises with WR_EN=0x3C in the same cycle: COUNT=1, RD_DATA=0x3C, UNF=1.
- Mid-stream RST low with COUNT=5 and BUSY high: all outputs return to reset values at once. After release with BUSY still high: UNF=1, COUNT=0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and helpers for the UART transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Byte width seen by the UART transmitter data port
    localparam int C_DATA_WIDTH = 8;

    // Default number of entries in the transmit feeder FIFO
    localparam int C_FIFO_DEPTH = 8;

    // Ceiling log2 for pointer sizing; returns 0 for value <= 1
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : uart_edge_det
// Description : Rising-edge detector. o_pulse is high for the single cycle in
//               which i_level is high and was low on the previous edge.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_edge_det (
    input  logic CLK,
    input  logic RST,
    input  logic i_level,
    output logic o_pulse
);

    logic r_level_d;

    // Remember the previous sample of the level input
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= i_level;
        end
    end

    assign o_pulse = i_level & ~r_level_d;

endmodule : uart_edge_det
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_feeder
// Description : First-word-fall-through FIFO feeding the UART transmitter.
//               The head byte is always presented on RD_DATA; the rising
//               edge of the transmitter's BUSY consumes it. Sticky OVF/UNF
//               flags record dropped writes and pops of an empty FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH = C_DATA_WIDTH,
    parameter  int DEPTH      = C_FIFO_DEPTH,
    localparam int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  BUSY,
    input  logic                  CLR_ERR,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  F_EMPTY,
    output logic                  FULL,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVF,
    output logic                  UNF
);

    localparam logic [ADDR_WIDTH:0]   C_DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_ovf;
    logic                  r_unf;

    logic w_pop_req;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;
    logic w_ovf_set;
    logic w_unf_set;

    // BUSY rising edge is the transmitter's request for the next byte
    uart_edge_det u_busy_edge (
        .CLK     (CLK),
        .RST     (RST),
        .i_level (BUSY),
        .o_pulse (w_pop_req)
    );

    // Status derived only from the registered occupancy
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH_CNT);

    // A pop frees a slot in the same cycle, so a full FIFO may still accept
    assign w_pop     = w_pop_req & ~w_empty;
    assign w_wr      = WR_EN & (~w_full | w_pop);
    assign w_ovf_set = WR_EN & w_full & ~w_pop;
    assign w_unf_set = w_pop_req & w_empty;

    // Storage and write pointer; memory is cleared so RD_DATA is defined
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= WR_DATA;
            r_wr_ptr        <= r_wr_ptr + C_PTR_ONE;
        end
    end

    // Read pointer advances on an accepted pop
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        end
    end

    // Occupancy: simultaneous write and pop leave it unchanged
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_count <= '0;
        end else begin
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes priority
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~CLR_ERR);
            r_unf <= w_unf_set | (r_unf & ~CLR_ERR);
        end
    end

    assign RD_DATA = r_mem[r_rd_ptr];
    assign F_EMPTY = w_empty;
    assign FULL    = w_full;
    assign COUNT   = r_count;
    assign OVF     = r_ovf;
    assign UNF     = r_unf;

endmodule : uart_tx_feeder
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_feeder
// Description : Directed, table-driven bench for uart_tx_feeder (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       busy;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       f_empty;
    logic       full;
    logic [3:0] count;
    logic       ovf;
    logic       unf;

    int n_checks;
    int n_pass;

    typedef struct {
        string      name;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       busy;
        logic       clr_err;
        logic       exp_empty;
        logic       exp_full;
        logic [3:0] exp_count;
        logic [7:0] exp_rd;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    vec_t vecs[$];

    uart_tx_feeder #(
        .DATA_WIDTH (8),
        .DEPTH      (8)
    ) dut (
        .CLK     (clk),
        .RST     (rst_n),
        .WR_EN   (wr_en),
        .WR_DATA (wr_data),
        .BUSY    (busy),
        .CLR_ERR (clr_err),
        .RD_DATA (rd_data),
        .F_EMPTY (f_empty),
        .FULL    (full),
        .COUNT   (count),
        .OVF     (ovf),
        .UNF     (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_all(input string tag, input logic e, input logic f,
                           input logic [3:0] c, input logic [7:0] rd,
                           input logic o, input logic u);
        chk({tag, ".empty"}, {31'd0, f_empty}, {31'd0, e});
        chk({tag, ".full"},  {31'd0, full},    {31'd0, f});
        chk({tag, ".count"}, {28'd0, count},   {28'd0, c});
        chk({tag, ".rd"},    {24'd0, rd_data}, {24'd0, rd});
        chk({tag, ".ovf"},   {31'd0, ovf},     {31'd0, o});
        chk({tag, ".unf"},   {31'd0, unf},     {31'd0, u});
    endtask

    function automatic void add(input string nm, input logic we, input logic [7:0] wd,
                                input logic bz, input logic ce, input logic e,
                                input logic f, input logic [3:0] c, input logic [7:0] rd,
                                input logic o, input logic u);
        vec_t v;
        v.name = nm; v.wr_en = we; v.wr_data = wd; v.busy = bz; v.clr_err = ce;
        v.exp_empty = e; v.exp_full = f; v.exp_count = c; v.exp_rd = rd;
        v.exp_ovf = o; v.exp_unf = u;
        vecs.push_back(v);
    endfunction

    task automatic step(input logic we, input logic [7:0] wd, input logic bz, input logic ce);
        wr_en = we; wr_data = wd; busy = bz; clr_err = ce;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pop_rd [8];
        logic [7:0] prev_rd;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        busy     = 1'b0;
        clr_err  = 1'b0;

        // ---------------- vector table ----------------
        //   name          we  data   bz  ce  emp ful cnt  rd     ovf unf
        add("idle",        0, 8'h00, 0,  0,  1,  0,  0,  8'h00, 0,  0);
        add("wr_a5",       1, 8'hA5, 0,  0,  0,  0,  1,  8'hA5, 0,  0);
        add("pop_a5",      0, 8'h00, 1,  0,  1,  0,  0,  8'h00, 0,  0);
        for (int i = 0; i < 11; i++)
            add("busy_hold", 0, 8'h00, 1, 0,  1,  0,  0,  8'h00, 0,  0);
        add("busy_fall",   0, 8'h00, 0,  0,  1,  0,  0,  8'h00, 0,  0);
        add("unf_empty",   0, 8'h00, 1,  0,  1,  0,  0,  8'h00, 0,  1);
        add("busy_low",    0, 8'h00, 0,  0,  1,  0,  0,  8'h00, 0,  1);
        add("clr_vs_set",  0, 8'h00, 1,  1,  1,  0,  0,  8'h00, 0,  1);
        add("clr_unf",     0, 8'h00, 1,  1,  1,  0,  0,  8'h00, 0,  0);
        for (int i = 1; i <= 8; i++)
            add("fill", 1, 8'(i), 0, 0, 0, (i == 8), 4'(i), 8'h01, 0, 0);
        add("ovf_drop",    1, 8'h09, 0,  0,  0,  1,  8,  8'h01, 1,  0);
        add("clr_ovf",     0, 8'h00, 0,  1,  0,  1,  8,  8'h01, 0,  0);
        add("full_wr_pop", 1, 8'h09, 1,  0,  0,  1,  8,  8'h02, 0,  0);
        pop_rd[0] = 8'h03; pop_rd[1] = 8'h04; pop_rd[2] = 8'h05; pop_rd[3] = 8'h06;
        pop_rd[4] = 8'h07; pop_rd[5] = 8'h08; pop_rd[6] = 8'h09; pop_rd[7] = 8'h02;
        prev_rd = 8'h02;
        for (int k = 0; k < 8; k++) begin
            add("drain_low", 0, 8'h00, 0, 0, 0, (k == 0), 4'(8 - k), prev_rd, 0, 0);
            add("drain_pop", 0, 8'h00, 1, 0, (k == 7), 0, 4'(7 - k), pop_rd[k], 0, 0);
            prev_rd = pop_rd[k];
        end
        add("idle_low",    0, 8'h00, 0,  0,  1,  0,  0,  8'h02, 0,  0);
        add("empty_wr_pop",1, 8'h3C, 1,  0,  0,  0,  1,  8'h3C, 0,  1);
        add("wr_11_hold",  1, 8'h11, 1,  0,  0,  0,  2,  8'h3C, 0,  1);
        add("wr_22_hold",  1, 8'h22, 1,  0,  0,  0,  3,  8'h3C, 0,  1);
        add("wr_33_hold",  1, 8'h33, 1,  0,  0,  0,  4,  8'h3C, 0,  1);
        add("wr_44_hold",  1, 8'h44, 1,  0,  0,  0,  5,  8'h3C, 0,  1);

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk_all("reset", 1, 0, 0, 8'h00, 0, 0);

        // ---------------- apply table ----------------
        foreach (vecs[i]) begin
            step(vecs[i].wr_en, vecs[i].wr_data, vecs[i].busy, vecs[i].clr_err);
            chk_all(vecs[i].name, vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_count,
                    vecs[i].exp_rd, vecs[i].exp_ovf, vecs[i].exp_unf);
        end

        // ---------------- mid-stream asynchronous reset ----------------
        // COUNT=5, BUSY high, UNF set; reset asserted between edges
        wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1, 0, 0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        chk_all("rst_held", 1, 0, 0, 8'h00, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // BUSY still high: first edge after release looks like a rise on empty
        @(posedge clk);
        #1;
        chk_all("post_rst_rise", 1, 0, 0, 8'h00, 0, 1);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        chk_all("post_rst_wr", 0, 0, 1, 8'h5A, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_tx_feeder
`default_nettype wire
